pulse_mod_counter: RTL and testbench

- Parametrised synchronous successor to the lab's mod-4 pulse-mode counter.
- Counts rising edges of switch-driven event inputs modulo MOD, up or down, with a synchronous clear.
- Each input passes through a synchroniser and an edge detector.
- Drives LEDs on the EGO1 board: the state vector y, a decode output z and a one-cycle wrap indicator.

---
 rtl/pulse_mod_counter_if.sv | 15 +
 rtl/pulse_mod_counter.sv | 121 ++++++++++++
 tb/tb_pulse_mod_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pulse_mod_counter_if.sv
// Event inputs and LED outputs of pulse_mod_counter, grouped as one bundle.
// The master drives the switch events; the slave (counter) drives y/z/wrap.
interface pulse_mod_counter_if #(
  parameter int W = 2
);
  logic         x1;
  logic         x2;
  logic         x3;
  logic [W-1:0] y;
  logic         z;
  logic         wrap;

  modport master (output x1, x2, x3, input y, z, wrap);
  modport slave  (input x1, x2, x3, output y, z, wrap);
endinterface

// File: rtl/pulse_mod_counter.sv
// Modulo-MOD up/down pulse counter driven by switch rising edges, with clear.
// Optional debounce filter enabled by defining PULSE_MOD_COUNTER_DEBOUNCE_EN.
module pulse_mod_counter #(
  parameter int MOD       = 4,
  parameter int W         = 2,
  parameter int Z_STATE   = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rd,
  pulse_mod_counter_if.slave bus
);

  generate
    if (MOD < 2 || (W < 63 && (longint'(1) << W) < longint'(MOD)) ||
        Z_STATE < 0 || Z_STATE >= MOD || DB_CYCLES < 1) begin : g_bad_param
      $error("pulse_mod_counter: illegal MOD/W/Z_STATE/DB_CYCLES combination");
    end
  endgenerate

  localparam logic [W-1:0] MAXV = W'(MOD - 1);
  localparam logic [W-1:0] ZV   = W'(Z_STATE);

  logic [2:0] xs;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] lvl;
  logic [2:0] ev;

  assign xs = {bus.x3, bus.x2, bus.x1};

  // Synchroniser; all stages reset high so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rd) begin
      s1_q <= '1;
      s2_q <= '1;
      s3_q <= '1;
    end else begin
      s1_q <= xs;
      s2_q <= s1_q;
      s3_q <= lvl;
    end
  end

`ifdef PULSE_MOD_COUNTER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    stab_q, stab_d;

  // Stable level flips only after DB_CYCLES consecutive mismatching samples.
  always_comb begin
    stab_d = stab_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stab_d[i] = ~stab_q[i];
        else                      cnt_d[i]  = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rd) begin
      stab_q <= '1;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      stab_q <= stab_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign lvl = stab_q;
`else
  assign lvl = s2_q;
`endif

  assign ev = lvl & ~s3_q;

  logic [W-1:0] y_q, y_d;
  logic         wrap_q, wrap_d;

  // Clear beats counting; simultaneous up and down cancel out.
  always_comb begin
    y_d    = y_q;
    wrap_d = 1'b0;
    if (ev[2]) begin
      y_d = '0;
    end else if (ev[0] && !ev[1]) begin
      if (y_q == MAXV) begin
        y_d    = '0;
        wrap_d = 1'b1;
      end else begin
        y_d = y_q + W'(1);
      end
    end else if (ev[1] && !ev[0]) begin
      if (y_q == '0) begin
        y_d    = MAXV;
        wrap_d = 1'b1;
      end else begin
        y_d = y_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rd) begin
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.wrap = wrap_q;
  assign bus.z    = (y_q == ZV);

endmodule

// File: tb/tb_pulse_mod_counter.sv
// Directed bench for pulse_mod_counter: a MOD=4 instance and a MOD=10 instance.
module tb_pulse_mod_counter;

  localparam int DB = 16;
`ifdef PULSE_MOD_COUNTER_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rd  = 1'b0;
  logic [3:1] xa  = '0;
  logic [3:1] xb  = '0;

  int n_run  = 0;
  int n_fail = 0;
  int cur_a  = 0;
  int cur_b  = 0;

  always #5 clk = ~clk;

  pulse_mod_counter_if #(.W(2)) ifa ();
  pulse_mod_counter_if #(.W(4)) ifb ();

  assign ifa.x1 = xa[1];
  assign ifa.x2 = xa[2];
  assign ifa.x3 = xa[3];
  assign ifb.x1 = xb[1];
  assign ifb.x2 = xb[2];
  assign ifb.x3 = xb[3];

  pulse_mod_counter #(.MOD(4), .W(2), .Z_STATE(1), .DB_CYCLES(DB)) u_dut_a (
    .clk (clk),
    .rd  (rd),
    .bus (ifa)
  );

  pulse_mod_counter #(.MOD(10), .W(4), .Z_STATE(1), .DB_CYCLES(DB)) u_dut_b (
    .clk (clk),
    .rd  (rd),
    .bus (ifb)
  );

  task automatic check_val(input string tag, input logic signed [31:0] obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_y(input bit sel_b);
    return sel_b ? int'(ifb.y) : int'(ifa.y);
  endfunction

  function automatic int get_w(input bit sel_b);
    return sel_b ? int'(ifb.wrap) : int'(ifa.wrap);
  endfunction

  function automatic int get_z(input bit sel_b);
    return sel_b ? int'(ifb.z) : int'(ifa.z);
  endfunction

  // Raise the mask, confirm y holds until the LAT-th edge, then check the update.
  task automatic pulse(input bit sel_b, input logic [3:1] m, input int exp_y,
                       input int exp_w, input string tag);
    int prev;
    prev = sel_b ? cur_b : cur_a;
    if (sel_b) xb = m; else xa = m;
    repeat (LAT) tick();
    check_val({tag, "_early"}, get_y(sel_b), prev);
    tick();
    check_val({tag, "_y"}, get_y(sel_b), exp_y);
    check_val({tag, "_wrap"}, get_w(sel_b), exp_w);
    check_val({tag, "_z"}, get_z(sel_b), (exp_y == 1) ? 1 : 0);
    if (sel_b) xb = '0; else xa = '0;
    tick();
    check_val({tag, "_wrap_clr"}, get_w(sel_b), 0);
    check_val({tag, "_y_hold"}, get_y(sel_b), exp_y);
    repeat (LAT + 1) tick();
    if (sel_b) cur_b = exp_y; else cur_a = exp_y;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rd = 1'b0;
    repeat (3) tick();
    check_val("rst_y_a", get_y(0), 0);
    check_val("rst_wrap_a", get_w(0), 0);
    check_val("rst_z_a", get_z(0), 0);
    check_val("rst_y_b", get_y(1), 0);
    rd = 1'b1;
    repeat (3) tick();

    pulse(0, 3'b001, 1, 0, "up1");
    pulse(0, 3'b001, 2, 0, "up2");
    pulse(0, 3'b001, 3, 0, "up3");
    pulse(0, 3'b001, 0, 1, "up4_wrap");

    pulse(0, 3'b010, 3, 1, "dn1_wrap");
    pulse(0, 3'b010, 2, 0, "dn2");

    pulse(0, 3'b011, 2, 0, "up_dn_cancel");
    pulse(0, 3'b101, 0, 0, "clr_with_up");

    // x1 held high across reset and beyond must not count.
    xa = 3'b001;
    rd = 1'b0;
    repeat (2) tick();
    rd = 1'b1;
    repeat (20) tick();
    check_val("held_y", get_y(0), 0);
    xa = '0;
    repeat (LAT + 2) tick();
    cur_a = 0;
    pulse(0, 3'b001, 1, 0, "after_hold");
    pulse(0, 3'b001, 2, 0, "pre_midrst");

    // Reset while an x1 edge is only in the first synchroniser stage.
    xa = 3'b001;
    tick();
    rd = 1'b0;
    tick();
    check_val("midrst_y", get_y(0), 0);
    check_val("midrst_wrap", get_w(0), 0);
    rd = 1'b1;
    repeat (LAT + 3) tick();
    check_val("midrst_no_inc", get_y(0), 0);
    xa = '0;
    repeat (LAT + 2) tick();
    cur_a = 0;

`ifdef PULSE_MOD_COUNTER_DEBOUNCE_EN
    xa = 3'b001;
    repeat (5) tick();
    xa = '0;
    repeat (3) tick();
    xa = 3'b001;
    repeat (18) tick();
    check_val("db_bounce_early", get_y(0), 0);
    tick();
    check_val("db_bounce_y", get_y(0), 1);
    repeat (6) tick();
    check_val("db_bounce_once", get_y(0), 1);
    xa = '0;
    repeat (LAT + 2) tick();
    xa = 3'b001;
    repeat (10) tick();
    xa = '0;
    repeat (LAT + 4) tick();
    check_val("db_glitch_y", get_y(0), 1);
    check_val("db_glitch_wrap", get_w(0), 0);
    cur_a = 1;
`endif

    check_val("b_idle_y", get_y(1), 0);
    for (int i = 0; i < 10; i++) begin
      pulse(1, 3'b001, (i + 1) % 10, (i == 9) ? 1 : 0, $sformatf("b_up%0d", i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
